switch_encoder: RTL and testbench

SWITCH_ENCODER -- requirements
Module: switch_encoder

---
 rtl/switch_pkg.sv | 17 +
 rtl/sw_debounce.sv | 47 ++++
 rtl/switch_encoder.sv | 141 ++++++++++++++
 tb/tb_switch_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | switch_pkg : shared types and default constants for switch_encoder    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package switch_pkg;

  localparam int N_SW_DEF       = 10;
  localparam int DEB_CYCLES_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } evt_state_t;

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sw_debounce : 2-flop synchroniser plus stability counter, one channel |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sw_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic db
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        // DEB_CYCLES-th consecutive mismatch: accept the new level
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/switch_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | switch_encoder : debounced switch bank, priority encoder, event FSM   |
// | Option macro SWITCH_ENCODER_STRICT_EN : multi-on is an error state    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module switch_encoder
  import switch_pkg::*;
#(
  parameter int  N_SW       = N_SW_DEF,
  parameter int  DEB_CYCLES = DEB_CYCLES_DEF,
  localparam int CODE_W     = ($clog2(N_SW) > 1) ? $clog2(N_SW) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SW-1:0]   sw,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              multi,
  output logic              err,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_ovf
);

  logic [N_SW-1:0]   w_db;
  logic [5:0]        w_pop;
  logic [CODE_W-1:0] w_code_enc;
  logic [CODE_W-1:0] w_code_nxt;
  logic              w_valid_nxt;
  logic              w_multi_nxt;
  logic              w_chg;

  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_multi;
  logic [CODE_W-1:0] r_evt_code;
  logic              r_evt_ovf;

  evt_state_t        r_state;
  evt_state_t        w_state_nxt;

  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_chan
      sw_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_in (sw[gi]),
        .db    (w_db[gi])
      );
    end
  endgenerate

  // Downward scan so the lowest set bit is the last assignment
  always_comb begin
    w_pop      = '0;
    w_code_enc = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      w_pop = w_pop + 6'(w_db[i]);
      if (w_db[i]) begin
        w_code_enc = CODE_W'(i);
      end
    end
    w_multi_nxt = (w_pop >= 6'd2);
`ifdef SWITCH_ENCODER_STRICT_EN
    w_valid_nxt = (w_pop != 6'd0) && !w_multi_nxt;
    w_code_nxt  = w_multi_nxt ? r_code : w_code_enc;
    w_chg       = !w_multi_nxt && ({w_valid_nxt, w_code_nxt} != {r_valid, r_code});
`else
    w_valid_nxt = (w_pop != 6'd0);
    w_code_nxt  = w_code_enc;
    w_chg       = ({w_valid_nxt, w_code_nxt} != {r_valid, r_code});
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_multi    <= 1'b0;
      r_evt_code <= '0;
      r_evt_ovf  <= 1'b0;
    end else begin
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_multi <= w_multi_nxt;
      if (w_chg) begin
        r_evt_code <= w_code_nxt;
      end
      if (w_chg && (r_state == PEND) && !evt_ready) begin
        r_evt_ovf <= 1'b1;
      end
    end
  end

`ifdef SWITCH_ENCODER_STRICT_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_multi_nxt;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_chg) w_state_nxt = PEND;
      PEND:    if (!w_chg && evt_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (r_state == PEND);
  end

  assign code     = r_code;
  assign valid    = r_valid;
  assign multi    = r_multi;
  assign evt_code = r_evt_code;
  assign evt_ovf  = r_evt_ovf;

endmodule
`default_nettype wire

// File: tb/tb_switch_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_switch_encoder : directed bench with a window-based reference model|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_switch_encoder;

  localparam int N  = 10;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  sw;
  logic [CW-1:0] code;
  logic          valid;
  logic          multi;
  logic          err;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_code;
  logic          evt_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  switch_encoder #(
    .N_SW       (N),
    .DEB_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .code      (code),
    .valid     (valid),
    .multi     (multi),
    .err       (err),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronised
  // samples all disagree with the accepted level.
`ifdef SWITCH_ENCODER_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic [N-1:0]  m_s1, m_s2, m_db;
  logic [N-1:0]  m_win [D];
  logic [CW-1:0] m_code, m_evt_code;
  logic          m_valid, m_multi, m_err, m_pend, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0;
      for (int k = 0; k < D; k++) m_win[k] <= '0;
      m_code <= '0; m_valid <= 1'b0; m_multi <= 1'b0; m_err <= 1'b0;
      m_pend <= 1'b0; m_ovf <= 1'b0; m_evt_code <= '0;
    end else begin
      logic [N-1:0]  iso, ndb;
      logic [N-1:0]  wn [D];
      logic [CW-1:0] nc;
      logic          nv, nm, ne, chg, flip;
      int            pc;
      pc  = $countones(m_db);
      iso = m_db & (~m_db + 1'b1);
      nc  = (m_db == '0) ? '0 : CW'($clog2(iso));
      nm  = (pc >= 2);
      nv  = (pc != 0);
      ne  = 1'b0;
      if (STRICT && nm) begin
        nv = 1'b0;
        ne = 1'b1;
        nc = m_code;
      end
      chg = !(STRICT && nm) && ((nv != m_valid) || (nc != m_code));
      if (chg) begin
        if (m_pend && !evt_ready) m_ovf <= 1'b1;
        m_pend     <= 1'b1;
        m_evt_code <= nc;
      end else if (m_pend && evt_ready) begin
        m_pend <= 1'b0;
      end
      m_code <= nc; m_valid <= nv; m_multi <= nm; m_err <= ne;
      wn[0] = m_s2;
      for (int k = 1; k < D; k++) wn[k] = m_win[k-1];
      ndb = m_db;
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int k = 0; k < D; k++) if (wn[k][i] == m_db[i]) flip = 1'b0;
        if (flip) ndb[i] = ~m_db[i];
      end
      for (int k = 0; k < D; k++) m_win[k] <= wn[k];
      m_db <= ndb;
      m_s2 <= m_s1;
      m_s1 <= sw;
    end
  end

  always @(negedge clk) begin
    chk("cyc_code",      32'(code),      32'(m_code));
    chk("cyc_valid",     32'(valid),     32'(m_valid));
    chk("cyc_multi",     32'(multi),     32'(m_multi));
    chk("cyc_err",       32'(err),       32'(m_err));
    chk("cyc_evt_valid", 32'(evt_valid), 32'(m_pend));
    chk("cyc_evt_code",  32'(evt_code),  32'(m_evt_code));
    chk("cyc_evt_ovf",   32'(evt_ovf),   32'(m_ovf));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"},      32'(code),      0);
    chk({tag, "_valid"},     32'(valid),     0);
    chk({tag, "_multi"},     32'(multi),     0);
    chk({tag, "_err"},       32'(err),       0);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 0);
    chk({tag, "_evt_code"},  32'(evt_code),  0);
    chk({tag, "_evt_ovf"},   32'(evt_ovf),   0);
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; evt_ready = 1'b0;
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(10);
    chk("idle_no_evt", 32'(evt_valid), 0);

    // single switch, exact latency and handshake
    sw = 10'b0000000100;
    step(6);
    chk("lat6_valid", 32'(valid), 0);
    step(1);
    chk("lat7_code",     32'(code),      2);
    chk("lat7_valid",    32'(valid),     1);
    chk("lat7_evt",      32'(evt_valid), 1);
    chk("lat7_evt_code", 32'(evt_code),  2);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("accept_evt", 32'(evt_valid), 0);
    chk("accept_ovf", 32'(evt_ovf),   0);

    // short glitch is rejected
    sw = 10'b0000100100;
    step(3);
    sw = 10'b0000000100;
    step(10);
    chk("glitch_code",  32'(code),      2);
    chk("glitch_valid", 32'(valid),     1);
    chk("glitch_evt",   32'(evt_valid), 0);
    chk("glitch_multi", 32'(multi),     0);

    // multiple switches
    evt_ready = 1'b1;
    sw = 10'b0010001000;
    step(8);
`ifdef SWITCH_ENCODER_STRICT_EN
    chk("m37_code",  32'(code),  2);
    chk("m37_valid", 32'(valid), 0);
    chk("m37_err",   32'(err),   1);
`else
    chk("m37_code",  32'(code),  3);
    chk("m37_valid", 32'(valid), 1);
    chk("m37_err",   32'(err),   0);
`endif
    chk("m37_multi", 32'(multi), 1);
    sw = 10'b0100000100;
    step(8);
`ifdef SWITCH_ENCODER_STRICT_EN
    chk("m28_valid", 32'(valid), 0);
    chk("m28_err",   32'(err),   1);
`else
    chk("m28_valid", 32'(valid), 1);
    chk("m28_err",   32'(err),   0);
`endif
    chk("m28_code",  32'(code),  2);
    sw = 10'b0000000100;
    step(8);
    chk("m2_code",  32'(code),  2);
    chk("m2_valid", 32'(valid), 1);
    chk("m2_err",   32'(err),   0);
    chk("m2_multi", 32'(multi), 0);
    evt_ready = 1'b0;
    step(1);
    chk("m2_evt", 32'(evt_valid), 0);

    // overwrite while pending, then accept with simultaneous change
    sw = 10'b0000000010;
    step(8);
    chk("ov1_evt",      32'(evt_valid), 1);
    chk("ov1_evt_code", 32'(evt_code),  1);
    chk("ov1_ovf",      32'(evt_ovf),   0);
    sw = 10'b0001000000;
    step(8);
    chk("ov6_code",     32'(code),      6);
    chk("ov6_evt_code", 32'(evt_code),  6);
    chk("ov6_ovf",      32'(evt_ovf),   1);
    sw = 10'b0000100000;
    step(6);
    chk("pre5_code", 32'(code), 6);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("acc_chg_code",     32'(code),      5);
    chk("acc_chg_evt",      32'(evt_valid), 1);
    chk("acc_chg_evt_code", 32'(evt_code),  5);
    chk("acc_chg_ovf",      32'(evt_ovf),   1);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("acc_evt", 32'(evt_valid), 0);
    chk("acc_ovf", 32'(evt_ovf),   1);

    // reset in the middle of a debounce
    sw = 10'b0000010000;
    step(4);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    step(6);
    chk("rel6_valid", 32'(valid), 0);
    step(1);
    chk("rel7_code",     32'(code),      4);
    chk("rel7_valid",    32'(valid),     1);
    chk("rel7_evt",      32'(evt_valid), 1);
    chk("rel7_evt_code", 32'(evt_code),  4);
    chk("rel7_ovf",      32'(evt_ovf),   0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
